// File: rtl/addsub_nibble_sequencer_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract sequencer.
package addsub_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    function automatic bit width_ok(input int unsigned w);
        return ((w % NIBBLE_W) == 0) && (w >= 8);
    endfunction

    // One full-adder cell: returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/addsub_nibble_sequencer_nibble_addsub.sv
// Combinational 4-bit add/subtract slice; invert and carry-in are independent
// so a borrow can ripple between nibbles in subtract mode.
module nibble_addsub
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                inv,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                c3,
    output logic                cout
);

    logic [NIBBLE_W:0]   c;
    logic [NIBBLE_W-1:0] b_eff;

    always_comb begin
        b_eff = b ^ {NIBBLE_W{inv}};
        c     = '0;
        s     = '0;
        c[0]  = cin;
        for (int k = 0; k < int'(NIBBLE_W); k++) begin
            {c[k+1], s[k]} = full_add(a[k], b_eff[k], c[k]);
        end
    end

    assign c3   = c[NIBBLE_W-1];
    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/addsub_nibble_sequencer.sv
// Wide add/subtract done one nibble per clock, LSB first, with the carry
// rippling through a register between cycles.
module addsub_nibble_sequencer
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N     = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("addsub_nibble_sequencer: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     idx;
    logic                 carry_q;
    logic                 sub_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    flags_t               flags_q;

    logic                 last;
    logic                 load;
    logic                 step;
    logic                 busy_nxt;
    logic                 done_nxt;

    logic [NIBBLE_W-1:0]  a_nib;
    logic [NIBBLE_W-1:0]  b_nib;
    logic [NIBBLE_W-1:0]  s_nib;
    logic                 c3_nib;
    logic                 co_nib;
    logic [WIDTH-1:0]     result_nxt;

    assign last = (idx == CNT_W'(N - 1));

    // State register; busy/done are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/control decode.
    always_comb begin
        load     = 1'b0;
        step     = 1'b0;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        load     = start && (state != RUN);
        step     = (state == RUN);
        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
    end

    // Pick the operand nibbles for the current index.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (idx == CNT_W'(k)) begin
                a_nib = a_q[k*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[k*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_addsub u_nibble (
        .a    (a_nib),
        .b    (b_nib),
        .inv  (sub_q),
        .cin  (carry_q),
        .s    (s_nib),
        .c3   (c3_nib),
        .cout (co_nib)
    );

    // Merge the freshly computed nibble into the result word.
    always_comb begin
        result_nxt = result;
        for (int k = 0; k < int'(N); k++) begin
            if (idx == CNT_W'(k)) begin
                result_nxt[k*NIBBLE_W +: NIBBLE_W] = s_nib;
            end
        end
    end

    // Operand, carry, result and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx     <= '0;
            result  <= '0;
            flags_q <= '0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            carry_q <= sub;
            idx     <= '0;
            result  <= '0;
        end else if (step) begin
            result  <= result_nxt;
            carry_q <= co_nib;
            idx     <= idx + CNT_W'(1);
            if (last) begin
                flags_q.cout <= co_nib;
                flags_q.ovf  <= c3_nib ^ co_nib;
                flags_q.zero <= (result_nxt == '0);
            end
        end
    end

    assign cout = flags_q.cout;
    assign ovf  = flags_q.ovf;
    assign zero = flags_q.zero;

endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Directed and randomized self-checking bench for addsub_nibble_sequencer.
module tb_addsub_nibble_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start16, sub16, busy16, done16, cout16, ovf16, zero16;
    logic [15:0] a16, b16, result16;
    logic        start8, sub8, busy8, done8, cout8, ovf8, zero8;
    logic [7:0]  a8, b8, result8;
    logic        start32, sub32, busy32, done32, cout32, ovf32, zero32;
    logic [31:0] a32, b32, result32;

    addsub_nibble_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .cout(cout16), .ovf(ovf16), .zero(zero16));
    addsub_nibble_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8), .zero(zero8));
    addsub_nibble_sequencer #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(result32), .cout(cout32), .ovf(ovf32), .zero(zero32));

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one 16-bit op and wait (bounded) for done; returns cycles and busy samples.
    task automatic op16(input logic s, input logic [15:0] x, input logic [15:0] y,
                        output int lat, output int busy_cnt);
        @(negedge clk);
        start16 = 1'b1; sub16 = s; a16 = x; b16 = y;
        @(negedge clk);
        start16 = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done16 && lat < 20) begin
            if (busy16) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y, output int lat);
        @(negedge clk);
        start8 = 1'b1; sub8 = s; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op32(input logic s, input logic [31:0] x, input logic [31:0] y, output int lat);
        @(negedge clk);
        start32 = 1'b1; sub32 = s; a32 = x; b32 = y;
        @(negedge clk);
        start32 = 1'b0;
        lat = 0;
        while (!done32 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t vecs[8];

    initial begin
        int lat, bc, cnt, seen;
        logic        s;
        logic [7:0]  x8, y8, bb8;
        logic [8:0]  r8;
        logic [31:0] x32, y32, bb32;
        logic [32:0] r32;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 16'h5555, 16'h5555, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        start16 = 0; sub16 = 0; a16 = 0; b16 = 0;
        start8  = 0; sub8  = 0; a8  = 0; b8  = 0;
        start32 = 0; sub32 = 0; a32 = 0; b32 = 0;
        repeat (3) @(negedge clk);
        check("reset busy",   32'(busy16), 32'd0);
        check("reset done",   32'(done16), 32'd0);
        check("reset result", 32'(result16), 32'd0);
        check("reset flags",  32'({cout16, ovf16, zero16}), 32'd0);
        rst_n = 1'b1;

        // Table-driven directed vectors.
        for (int i = 0; i < 8; i++) begin
            op16(vecs[i].sub, vecs[i].a, vecs[i].b, lat, bc);
            check($sformatf("v%0d latency", i), 32'(lat), 32'd4);
            check($sformatf("v%0d busy cycles", i), 32'(bc), 32'd4);
            check($sformatf("v%0d result", i), 32'(result16), 32'(vecs[i].res));
            check($sformatf("v%0d cout", i), 32'(cout16), 32'(vecs[i].cout));
            check($sformatf("v%0d ovf", i), 32'(ovf16), 32'(vecs[i].ovf));
            check($sformatf("v%0d zero", i), 32'(zero16), 32'(vecs[i].zero));
            @(negedge clk);
            check($sformatf("v%0d done pulse", i), 32'(done16), 32'd0);
            check($sformatf("v%0d result hold", i), 32'(result16), 32'(vecs[i].res));
        end

        // New start clears result but flags hold until the op completes.
        op16(1'b1, 16'h5555, 16'h5555, lat, bc);
        @(negedge clk);
        start16 = 1'b1; sub16 = 1'b0; a16 = 16'h1234; b16 = 16'h0FFF;
        @(negedge clk);
        start16 = 1'b0;
        check("start clears result", 32'(result16), 32'd0);
        check("flags hold on start", 32'({cout16, ovf16, zero16}), 32'b101);

        // Start pulses during RUN with different operands are ignored.
        a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        start16 = 1'b1;
        cnt = 0;
        while (!done16 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        start16 = 1'b0;
        check("ignored start result", 32'(result16), 32'h2233);
        check("ignored start flags", 32'({cout16, ovf16, zero16}), 32'b000);
        repeat (2) @(negedge clk);

        // Back-to-back: start in the done cycle.
        op16(1'b0, 16'h0100, 16'h0023, lat, bc);
        check("b2b first result", 32'(result16), 32'h0123);
        start16 = 1'b1; sub16 = 1'b1; a16 = 16'h0010; b16 = 16'h0001;
        @(negedge clk);
        start16 = 1'b0;
        cnt = 1;
        while (!done16 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b done spacing", 32'(cnt), 32'd5);
        check("b2b second result", 32'(result16), 32'h000F);
        check("b2b second cout", 32'(cout16), 32'd1);

        // Reset in the second RUN cycle aborts the op.
        @(negedge clk);
        start16 = 1'b1; sub16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy",   32'(busy16), 32'd0);
        check("abort done",   32'(done16), 32'd0);
        check("abort result", 32'(result16), 32'd0);
        check("abort flags",  32'({cout16, ovf16, zero16}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done16 || busy16) seen++;
        end
        check("abort no done", 32'(seen), 32'd0);
        op16(1'b0, 16'h0001, 16'h0001, lat, bc);
        check("post-abort result", 32'(result16), 32'h0002);
        check("post-abort latency", 32'(lat), 32'd4);

        // Randomized against a reference model, WIDTH = 8 and 32.
        for (int i = 0; i < 20; i++) begin
            s   = 1'($urandom_range(0, 1));
            x8  = 8'($urandom);
            y8  = 8'($urandom);
            bb8 = s ? ~y8 : y8;
            r8  = {1'b0, x8} + {1'b0, bb8} + 9'(s);
            op8(s, x8, y8, lat);
            check($sformatf("w8 #%0d latency", i), 32'(lat), 32'd2);
            check($sformatf("w8 #%0d result", i), 32'(result8), 32'(r8[7:0]));
            check($sformatf("w8 #%0d flags", i), 32'({cout8, ovf8, zero8}),
                  32'({r8[8], (x8[7] == bb8[7]) && (r8[7] != x8[7]), r8[7:0] == 8'd0}));

            s    = 1'($urandom_range(0, 1));
            x32  = $urandom;
            y32  = (i == 0) ? x32 : $urandom;
            bb32 = s ? ~y32 : y32;
            r32  = {1'b0, x32} + {1'b0, bb32} + 33'(s);
            op32(s, x32, y32, lat);
            check($sformatf("w32 #%0d latency", i), 32'(lat), 32'd8);
            check($sformatf("w32 #%0d result", i), result32, r32[31:0]);
            check($sformatf("w32 #%0d flags", i), 32'({cout32, ovf32, zero32}),
                  32'({r32[32], (x32[31] == bb32[31]) && (r32[31] != x32[31]), r32[31:0] == 32'd0}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
